// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer with call/return stack; redirects land one cycle after the request edge.
// stall freezes PC, state and stack; fetch_valid is the only output qualified by stall in the same cycle.
module pc_sequencer #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             RAS_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         br_en,
    input  logic [D-1:0] br_offset,
    input  logic         jmp_en,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic [D-1:0] jmp_addr,
    input  logic         halt_req,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid,
    output logic         done,
    output logic         stack_err
);

    localparam int SPW = $clog2(RAS_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]     state;
    logic [SPW:0]   sp;
    logic [SPW:0]   sp_dec;
    logic [D-1:0]   ras [RAS_DEPTH];
    logic           stack_empty;
    logic           stack_full;

    // sp counts occupied entries, so it needs one bit more than the entry index
    assign sp_dec      = sp - 1'b1;
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == (SPW+1)'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prog_ctr  <= START_ADDR;
            sp        <= '0;
            stack_err <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        prog_ctr <= START_ADDR;
                        sp       <= '0;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            state <= S_HALT;
                        end else if (ret_en) begin
                            if (stack_empty) begin
                                state     <= S_HALT;
                                stack_err <= 1'b1;
                            end else begin
                                prog_ctr <= ras[sp_dec[SPW-1:0]];
                                sp       <= sp_dec;
                            end
                        end else if (call_en) begin
                            if (stack_full) begin
                                state     <= S_HALT;
                                stack_err <= 1'b1;
                            end else begin
                                ras[sp[SPW-1:0]] <= prog_ctr + 1'b1;
                                sp               <= sp + 1'b1;
                                prog_ctr         <= jmp_addr;
                            end
                        end else if (jmp_en) begin
                            prog_ctr <= jmp_addr;
                        end else if (br_en) begin
                            prog_ctr <= prog_ctr + br_offset;
                        end else begin
                            prog_ctr <= prog_ctr + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    // restart clears only the pointer; stale entries are unreachable
                    if (start) begin
                        state     <= S_RUN;
                        prog_ctr  <= START_ADDR;
                        sp        <= '0;
                        stack_err <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_valid = (state == S_RUN) && !stall;
    assign done        = (state == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer with a queue-based reference model and scoreboard.
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset, start, stall, br_en, jmp_en, call_en, ret_en, halt_req;
    logic [D-1:0] br_offset, jmp_addr;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid, done, stack_err;

    pc_sequencer #(.D(D), .START_ADDR(12'h000), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .br_en(br_en), .br_offset(br_offset), .jmp_en(jmp_en),
        .call_en(call_en), .ret_en(ret_en), .jmp_addr(jmp_addr),
        .halt_req(halt_req), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
        .done(done), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst, st, stl, br, jmp, call, ret, hlt;
        logic [D-1:0] off, addr;
    } stim_t;

    typedef struct packed {
        logic [D-1:0] pc;
        logic         fv, dn, err;
    } resp_t;

    // reference model: mode 0=idle, 1=running, 2=halted; stack as a queue
    int           m_mode = 0;
    logic [D-1:0] m_pc   = '0;
    logic         m_err  = 1'b0;
    logic [D-1:0] m_stk[$];

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_cyc   = 0;

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic model_step(input stim_t s);
        if (s.rst) begin
            m_mode = 0; m_pc = '0; m_err = 1'b0; m_stk.delete();
        end else if (m_mode == 0) begin
            if (s.st) begin m_mode = 1; m_pc = '0; m_stk.delete(); end
        end else if (m_mode == 2) begin
            if (s.st) begin m_mode = 1; m_pc = '0; m_err = 1'b0; m_stk.delete(); end
        end else if (!s.stl) begin
            if (s.hlt) begin
                m_mode = 2;
            end else if (s.ret) begin
                if (m_stk.size() == 0) begin m_mode = 2; m_err = 1'b1; end
                else m_pc = m_stk.pop_back();
            end else if (s.call) begin
                if (m_stk.size() >= DEPTH) begin m_mode = 2; m_err = 1'b1; end
                else begin m_stk.push_back(D'(m_pc + 1)); m_pc = s.addr; end
            end else if (s.jmp) begin
                m_pc = s.addr;
            end else if (s.br) begin
                m_pc = D'(m_pc + s.off);
            end else begin
                m_pc = D'(m_pc + 1);
            end
        end
    endtask

    // apply one cycle of stimulus, queue the outputs expected during that cycle, then advance the model
    task automatic drv(input stim_t s);
        resp_t r;
        @(posedge clk);
        #1;
        reset = s.rst; start = s.st; stall = s.stl; br_en = s.br; jmp_en = s.jmp;
        call_en = s.call; ret_en = s.ret; halt_req = s.hlt; br_offset = s.off; jmp_addr = s.addr;
        r.pc  = m_pc;
        r.fv  = (m_mode == 1) && !s.stl;
        r.dn  = (m_mode == 2);
        r.err = m_err;
        exp_q.push_back(r);
        model_step(s);
    endtask

    always @(negedge clk) begin
        resp_t e;
        n_cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (prog_ctr !== e.pc || fetch_valid !== e.fv || done !== e.dn || stack_err !== e.err) begin
                n_fail++;
                $display("FAIL cyc%0d outputs: got pc=%h fv=%b done=%b err=%b, expected pc=%h fv=%b done=%b err=%b",
                         n_cyc, prog_ctr, fetch_valid, done, stack_err, e.pc, e.fv, e.dn, e.err);
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; start = 1'b0; stall = 1'b0; br_en = 1'b0; jmp_en = 1'b0;
        call_en = 1'b0; ret_en = 1'b0; halt_req = 1'b0; br_offset = '0; jmp_addr = '0;
        @(posedge clk); @(posedge clk);

        s = nop(); s.rst = 1'b1; drv(s);
        // start in the same cycle as reset must lose
        s.st = 1'b1; drv(s);
        drv(nop());
        s = nop(); s.br = 1'b1; s.jmp = 1'b1; s.addr = 12'h055; drv(s);
        s = nop(); s.st = 1'b1; drv(s);
        for (int i = 0; i < 3; i++) drv(nop());

        while (m_pc != 12'h010) drv(nop());
        s = nop(); s.br = 1'b1; s.off = 12'hFFC; drv(s);
        s = nop(); s.br = 1'b1; s.off = 12'h000; drv(s);
        s = nop(); s.jmp = 1'b1; s.addr = 12'hFFF; drv(s);
        drv(nop()); drv(nop());
        s = nop(); s.br = 1'b1; s.off = 12'h003; drv(s);

        s = nop(); s.jmp = 1'b1; s.addr = 12'h020; drv(s);
        s = nop(); s.call = 1'b1; s.addr = 12'h100; drv(s);
        drv(nop()); drv(nop());
        s = nop(); s.ret = 1'b1; drv(s);
        drv(nop());

        for (int i = 0; i < 5; i++) begin
            s = nop(); s.call = 1'b1; s.addr = 12'h200 + 12'(i * 16); drv(s);
        end
        drv(nop());
        s = nop(); s.st = 1'b1; drv(s);
        drv(nop());

        s = nop(); s.stl = 1'b1; s.br = 1'b1; s.off = 12'h040;
        for (int i = 0; i < 3; i++) drv(s);
        drv(nop());
        s = nop(); s.hlt = 1'b1; s.jmp = 1'b1; s.addr = 12'h3AA; drv(s);
        drv(nop());
        s = nop(); s.st = 1'b1; drv(s);

        s = nop(); s.ret = 1'b1; drv(s);
        drv(nop());
        s = nop(); s.st = 1'b1; drv(s);
        s = nop(); s.call = 1'b1; s.addr = 12'h0F0; drv(s);
        drv(nop());
        s = nop(); s.rst = 1'b1; s.stl = 1'b1; drv(s);
        drv(nop());
        s = nop(); s.st = 1'b1; drv(s);
        s = nop(); s.ret = 1'b1; drv(s);

        for (int i = 0; i < 3000; i++) begin
            s = nop();
            s.rst  = ($urandom_range(0, 199) == 0);
            s.st   = ($urandom_range(0, 15) == 0);
            s.stl  = ($urandom_range(0, 4) == 0);
            s.hlt  = ($urandom_range(0, 39) == 0);
            s.ret  = ($urandom_range(0, 6) == 0);
            s.call = ($urandom_range(0, 6) == 0);
            s.jmp  = ($urandom_range(0, 7) == 0);
            s.br   = ($urandom_range(0, 4) == 0);
            s.off  = D'($urandom);
            s.addr = D'($urandom);
            drv(s);
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
